// File: rtl/vscale_pc_gen.sv
// vscale_pc_gen: next-PC generator for the fetch stage.
//
// Picks the next fetch address from one of seven sources and holds the
// registered fetch PC. Stall and replay are handled here. A small circular
// return-address stack (RAS) supplies predicted return targets. Any accepted
// redirect whose target has bit 1 set is flagged as misaligned.
//
// Ports:
//   clk               sole clock, rising edge
//   reset             synchronous, active-high; wins over stall and selects
//   stall_IF          hold PC_IF, the RAS and target_misaligned
//   PC_src_sel[2:0]   next-PC source select:
//                       0 +4, 1 JAL, 2 JALR, 3 branch, 4 replay,
//                       5 stvec, 6 RAS, 7 treated as +4
//   inst_DX[31:0]     DX instruction; the B-immediate is taken from it
//   alu_out           JAL target
//   rs1_data          JALR target, also the fallback when the RAS is empty
//   PC_DX             DX-stage PC (branch base and call return address)
//   csr_stvec         trap vector
//   ras_push_DX       DX holds a call; push PC_DX + 4
//   PC_PIF            combinational next PC
//   PC_IF             registered fetch PC
//   target_misaligned set when the last accepted redirect had bit 1 set
//   ras_empty         RAS holds no valid entries
//   ras_count         number of valid RAS entries
module vscale_pc_gen #(
  parameter int unsigned          XLEN         = 32,
  parameter int unsigned          RAS_DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_VECTOR = 'h200
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall_IF,
  input  logic [2:0]                     PC_src_sel,
  input  logic [31:0]                    inst_DX,
  input  logic [XLEN-1:0]                alu_out,
  input  logic [XLEN-1:0]                rs1_data,
  input  logic [XLEN-1:0]                PC_DX,
  input  logic [XLEN-1:0]                csr_stvec,
  input  logic                           ras_push_DX,
  output logic [XLEN-1:0]                PC_PIF,
  output logic [XLEN-1:0]                PC_IF,
  output logic                           target_misaligned,
  output logic                           ras_empty,
  output logic [$clog2(RAS_DEPTH):0]     ras_count
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] SEL_PLUS_FOUR = 3'd0;
  localparam logic [2:0] SEL_JAL       = 3'd1;
  localparam logic [2:0] SEL_REG       = 3'd2;
  localparam logic [2:0] SEL_BRANCH    = 3'd3;
  localparam logic [2:0] SEL_REPLAY    = 3'd4;
  localparam logic [2:0] SEL_STVEC     = 3'd5;
  localparam logic [2:0] SEL_RAS       = 3'd6;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_top;
  logic [CW-1:0]   count_q;

  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] branch_imm;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] ret_addr;
  logic [XLEN-1:0] ras_top_data;
  logic            accept;
  logic            sel_ras;
  logic            redirect;
  logic            ras_nonempty;
  logic [PW-1:0]   ras_wr_idx;
  logic            ras_wr_en;

  // Only the B-immediate fields of the instruction are used.
  logic unused_inst;
  assign unused_inst = ^{inst_DX[24:12], inst_DX[6:0]};

  assign pc_plus_4     = PC_IF + XLEN'(4);
  assign branch_imm    = {{(XLEN-13){inst_DX[31]}}, inst_DX[31], inst_DX[7],
                          inst_DX[30:25], inst_DX[11:8], 1'b0};
  assign branch_target = PC_DX + branch_imm;
  assign ret_addr      = PC_DX + XLEN'(4);

  assign accept        = !reset && !stall_IF;
  assign sel_ras       = (PC_src_sel == SEL_RAS);
  assign ras_nonempty  = (count_q != '0);
  assign ras_top_data  = ras_mem[ras_top];
  assign ras_empty     = !ras_nonempty;
  assign ras_count     = count_q;

  // Push+pop in the same cycle replaces the top entry in place; a plain push
  // goes one slot above the current top (wrapping over the oldest entry).
  assign ras_wr_idx    = sel_ras ? ras_top : ras_top + PW'(1);
  assign ras_wr_en     = accept && ras_push_DX;

  always_comb begin
    PC_PIF   = pc_plus_4;
    redirect = 1'b0;
    if (reset) begin
      PC_PIF = RESET_VECTOR;
    end else begin
      case (PC_src_sel)
        SEL_JAL:    begin PC_PIF = alu_out;       redirect = 1'b1; end
        SEL_REG:    begin PC_PIF = rs1_data;      redirect = 1'b1; end
        SEL_BRANCH: begin PC_PIF = branch_target; redirect = 1'b1; end
        SEL_REPLAY: PC_PIF = PC_IF;
        SEL_STVEC:  begin PC_PIF = csr_stvec;     redirect = 1'b1; end
        SEL_RAS: begin
          PC_PIF   = ras_nonempty ? ras_top_data : rs1_data;
          redirect = 1'b1;
        end
        default:    PC_PIF = pc_plus_4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_IF             <= RESET_VECTOR;
      target_misaligned <= 1'b0;
      ras_top           <= '0;
      count_q           <= '0;
    end else if (!stall_IF) begin
      PC_IF             <= PC_PIF;
      target_misaligned <= redirect && PC_PIF[1];
      if (ras_push_DX && !sel_ras) begin
        ras_top <= ras_top + PW'(1);
        if (count_q != CW'(RAS_DEPTH))
          count_q <= count_q + CW'(1);
      end else if (sel_ras && !ras_push_DX && ras_nonempty) begin
        ras_top <= ras_top - PW'(1);
        count_q <= count_q - CW'(1);
      end else if (sel_ras && ras_push_DX && !ras_nonempty) begin
        count_q <= CW'(1);
      end
    end
  end

  // Entry storage carries no reset; only the count decides validity.
  always_ff @(posedge clk) begin
    if (ras_wr_en)
      ras_mem[ras_wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_vscale_pc_gen.sv
module tb_vscale_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_IF;
  logic [2:0]  PC_src_sel;
  logic [31:0] inst_DX;
  logic [31:0] alu_out;
  logic [31:0] rs1_data;
  logic [31:0] PC_DX;
  logic [31:0] csr_stvec;
  logic        ras_push_DX;
  logic [31:0] PC_PIF;
  logic [31:0] PC_IF;
  logic        target_misaligned;
  logic        ras_empty;
  logic [2:0]  ras_count;

  int total = 0;
  int bad   = 0;

  vscale_pc_gen #(.XLEN(32), .RAS_DEPTH(4), .RESET_VECTOR(32'h200)) dut (
    .clk(clk), .reset(reset), .stall_IF(stall_IF), .PC_src_sel(PC_src_sel),
    .inst_DX(inst_DX), .alu_out(alu_out), .rs1_data(rs1_data), .PC_DX(PC_DX),
    .csr_stvec(csr_stvec), .ras_push_DX(ras_push_DX), .PC_PIF(PC_PIF),
    .PC_IF(PC_IF), .target_misaligned(target_misaligned),
    .ras_empty(ras_empty), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    stall_IF = 0; PC_src_sel = 3'd0; inst_DX = 32'h0; alu_out = 32'h0;
    rs1_data = 32'h0; PC_DX = 32'h0; csr_stvec = 32'h0; ras_push_DX = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    settle();
    total++; if (PC_IF !== 32'h200) begin bad++; $display("FAIL reset_pc_if got=%h exp=%h", PC_IF, 32'h200); end
    total++; if (PC_PIF !== 32'h200) begin bad++; $display("FAIL reset_pc_pif got=%h exp=%h", PC_PIF, 32'h200); end
    total++; if (target_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%b exp=0", target_misaligned); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    reset = 0;
    settle();
    total++; if (PC_IF !== 32'h200) begin bad++; $display("FAIL release_pc_if got=%h exp=%h", PC_IF, 32'h200); end
    tick();
    total++; if (PC_IF !== 32'h204) begin bad++; $display("FAIL plus4_1 got=%h exp=%h", PC_IF, 32'h204); end
    tick();
    total++; if (PC_IF !== 32'h208) begin bad++; $display("FAIL plus4_2 got=%h exp=%h", PC_IF, 32'h208); end
    tick();
    total++; if (PC_IF !== 32'h20C) begin bad++; $display("FAIL plus4_3 got=%h exp=%h", PC_IF, 32'h20C); end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL plus4_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_branch;
    PC_src_sel = 3'd1; alu_out = 32'h100;
    tick();
    total++; if (PC_IF !== 32'h100) begin bad++; $display("FAIL jal_pc_if got=%h exp=%h", PC_IF, 32'h100); end
    // imm = -8
    PC_src_sel = 3'd3; inst_DX = 32'hFE000CE3; PC_DX = 32'hFC;
    settle();
    total++; if (PC_PIF !== 32'hF4) begin bad++; $display("FAIL br_neg_pif got=%h exp=%h", PC_PIF, 32'hF4); end
    tick();
    total++; if (PC_IF !== 32'hF4) begin bad++; $display("FAIL br_neg_pc_if got=%h exp=%h", PC_IF, 32'hF4); end
    total++; if (target_misaligned !== 1'b0) begin bad++; $display("FAIL br_neg_mis got=%b exp=0", target_misaligned); end
    PC_DX = 32'hFE;
    settle();
    total++; if (PC_PIF !== 32'hF6) begin bad++; $display("FAIL br_mis_pif got=%h exp=%h", PC_PIF, 32'hF6); end
    tick();
    total++; if (PC_IF !== 32'hF6) begin bad++; $display("FAIL br_mis_pc_if got=%h exp=%h", PC_IF, 32'hF6); end
    total++; if (target_misaligned !== 1'b1) begin bad++; $display("FAIL br_mis_flag got=%b exp=1", target_misaligned); end
    // imm = +16
    inst_DX = 32'h00000863; PC_DX = 32'h100;
    settle();
    total++; if (PC_PIF !== 32'h110) begin bad++; $display("FAIL br_pos_pif got=%h exp=%h", PC_PIF, 32'h110); end
    // +4 from a misaligned PC clears the flag even though bit 1 is set
    PC_src_sel = 3'd0;
    tick();
    total++; if (PC_IF !== 32'hFA) begin bad++; $display("FAIL plus4_mis_pc got=%h exp=%h", PC_IF, 32'hFA); end
    total++; if (target_misaligned !== 1'b0) begin bad++; $display("FAIL plus4_mis_flag got=%b exp=0", target_misaligned); end
  endtask

  task automatic test_selects;
    PC_src_sel = 3'd2; rs1_data = 32'h1234;
    settle();
    total++; if (PC_PIF !== 32'h1234) begin bad++; $display("FAIL sel_reg got=%h exp=%h", PC_PIF, 32'h1234); end
    tick();
    PC_src_sel = 3'd4;
    settle();
    total++; if (PC_PIF !== 32'h1234) begin bad++; $display("FAIL sel_replay_pif got=%h exp=%h", PC_PIF, 32'h1234); end
    tick();
    total++; if (PC_IF !== 32'h1234) begin bad++; $display("FAIL sel_replay_pc got=%h exp=%h", PC_IF, 32'h1234); end
    PC_src_sel = 3'd5; csr_stvec = 32'h8002;
    settle();
    total++; if (PC_PIF !== 32'h8002) begin bad++; $display("FAIL sel_stvec got=%h exp=%h", PC_PIF, 32'h8002); end
    tick();
    total++; if (target_misaligned !== 1'b1) begin bad++; $display("FAIL stvec_mis got=%b exp=1", target_misaligned); end
    PC_src_sel = 3'd7;
    settle();
    total++; if (PC_PIF !== 32'h8006) begin bad++; $display("FAIL sel_7 got=%h exp=%h", PC_PIF, 32'h8006); end
    tick();
    total++; if (target_misaligned !== 1'b0) begin bad++; $display("FAIL sel7_mis got=%b exp=0", target_misaligned); end
  endtask

  task automatic test_ras_overflow;
    logic [31:0] exp_pops [4];
    exp_pops[0] = 32'h54; exp_pops[1] = 32'h44; exp_pops[2] = 32'h34; exp_pops[3] = 32'h24;
    PC_src_sel = 3'd0; ras_push_DX = 1;
    for (int i = 1; i <= 5; i++) begin
      PC_DX = 32'h10 * i;
      tick();
    end
    ras_push_DX = 0;
    total++; if (ras_count !== 3'd4) begin bad++; $display("FAIL ras_full_count got=%0d exp=4", ras_count); end
    PC_src_sel = 3'd6; rs1_data = 32'hDEAD0000;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++; if (PC_PIF !== exp_pops[i]) begin bad++; $display("FAIL ras_pop%0d got=%h exp=%h", i, PC_PIF, exp_pops[i]); end
      tick();
    end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL ras_drained_empty got=%b exp=1", ras_empty); end
    settle();
    total++; if (PC_PIF !== 32'hDEAD0000) begin bad++; $display("FAIL ras_fallback got=%h exp=%h", PC_PIF, 32'hDEAD0000); end
    tick();
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL ras_underflow_count got=%0d exp=0", ras_count); end
  endtask

  task automatic test_push_pop;
    PC_src_sel = 3'd0; ras_push_DX = 1;
    PC_DX = 32'h20; tick();
    PC_DX = 32'h30; tick();
    PC_src_sel = 3'd6; PC_DX = 32'h80;
    settle();
    total++; if (PC_PIF !== 32'h34) begin bad++; $display("FAIL pushpop_pif got=%h exp=%h", PC_PIF, 32'h34); end
    tick();
    total++; if (ras_count !== 3'd2) begin bad++; $display("FAIL pushpop_count got=%0d exp=2", ras_count); end
    ras_push_DX = 0;
    settle();
    total++; if (PC_PIF !== 32'h84) begin bad++; $display("FAIL pushpop_top got=%h exp=%h", PC_PIF, 32'h84); end
    tick();
    settle();
    total++; if (PC_PIF !== 32'h24) begin bad++; $display("FAIL pushpop_next got=%h exp=%h", PC_PIF, 32'h24); end
    tick();
    // push+pop on an empty stack: fall back to rs1, count becomes 1
    ras_push_DX = 1; PC_DX = 32'h90; rs1_data = 32'h776;
    settle();
    total++; if (PC_PIF !== 32'h776) begin bad++; $display("FAIL pushpop_empty_pif got=%h exp=%h", PC_PIF, 32'h776); end
    tick();
    total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL pushpop_empty_count got=%0d exp=1", ras_count); end
    total++; if (target_misaligned !== 1'b1) begin bad++; $display("FAIL pushpop_empty_mis got=%b exp=1", target_misaligned); end
    ras_push_DX = 0;
    settle();
    total++; if (PC_PIF !== 32'h94) begin bad++; $display("FAIL pushpop_empty_top got=%h exp=%h", PC_PIF, 32'h94); end
    tick();
  endtask

  task automatic test_stall;
    logic [31:0] held;
    PC_src_sel = 3'd0; ras_push_DX = 1; PC_DX = 32'h60;
    tick();
    held = PC_IF;
    total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL stall_pre_count got=%0d exp=1", ras_count); end
    stall_IF = 1; PC_src_sel = 3'd1; alu_out = 32'h400; ras_push_DX = 1; PC_DX = 32'hA0;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (PC_PIF !== 32'h400) begin bad++; $display("FAIL stall_pif%0d got=%h exp=%h", i, PC_PIF, 32'h400); end
      tick();
      total++; if (PC_IF !== held) begin bad++; $display("FAIL stall_pc%0d got=%h exp=%h", i, PC_IF, held); end
      total++; if (ras_count !== 3'd1) begin bad++; $display("FAIL stall_count%0d got=%0d exp=1", i, ras_count); end
    end
    stall_IF = 0; ras_push_DX = 0;
    tick();
    total++; if (PC_IF !== 32'h400) begin bad++; $display("FAIL unstall_pc got=%h exp=%h", PC_IF, 32'h400); end
    PC_src_sel = 3'd6;
    settle();
    total++; if (PC_PIF !== 32'h64) begin bad++; $display("FAIL stall_ras_top got=%h exp=%h", PC_PIF, 32'h64); end
    tick();
  endtask

  task automatic test_wrap_and_reset;
    PC_src_sel = 3'd1; alu_out = 32'hFFFF_FFFC;
    tick();
    PC_src_sel = 3'd0;
    settle();
    total++; if (PC_PIF !== 32'h0) begin bad++; $display("FAIL wrap_pif got=%h exp=%h", PC_PIF, 32'h0); end
    tick();
    total++; if (PC_IF !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", PC_IF, 32'h0); end
    ras_push_DX = 1;
    PC_DX = 32'h100; tick();
    PC_DX = 32'h200; tick();
    PC_DX = 32'h300; tick();
    total++; if (ras_count !== 3'd3) begin bad++; $display("FAIL prereset_count got=%0d exp=3", ras_count); end
    reset = 1; stall_IF = 1; PC_src_sel = 3'd1; alu_out = 32'h999;
    settle();
    total++; if (PC_PIF !== 32'h200) begin bad++; $display("FAIL inreset_pif got=%h exp=%h", PC_PIF, 32'h200); end
    tick();
    total++; if (PC_IF !== 32'h200) begin bad++; $display("FAIL midreset_pc got=%h exp=%h", PC_IF, 32'h200); end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", ras_count); end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL midreset_empty got=%b exp=1", ras_empty); end
    reset = 0; idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_branch();
    test_selects();
    test_ras_overflow();
    test_push_pop();
    test_stall();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/vscale_pc_gen.md
# vscale_pc_gen

Parametrised next-PC generator for the fetch stage: it selects the next fetch address from seven sources and owns the registered `PC_IF` with stall and replay handling. It adds a small return-address stack (RAS) for predicted returns and flags misaligned redirect targets. It sits between the control unit, which drives `PC_src_sel`, `stall_IF` and the RAS push request, and the instruction-memory address port.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.
- `RESET_VECTOR`, 32'h200: `PC_IF` value after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall_IF`  in  1  hold `PC_IF`; suppress RAS updates.
- `PC_src_sel`  in  3  0 PLUS_FOUR, 1 JAL_TARGET, 2 REG_TARGET, 3 BRANCH_TARGET, 4 REPLAY, 5 STVEC, 6 RAS_TARGET, 7 reserved (treated as PLUS_FOUR).
- `inst_DX`  in  32  DX instruction; B-immediate source.
- `alu_out`  in  XLEN  JAL target.
- `rs1_data`  in  XLEN  JALR target; RAS fallback.
- `PC_DX`  in  XLEN  DX-stage PC.
- `csr_stvec`  in  XLEN  trap vector.
- `ras_push_DX`  in  1  DX holds a call; push `PC_DX + 4`.
- `PC_PIF`  out  XLEN  combinational next PC.
- `PC_IF`  out  XLEN  registered fetch PC.
- `target_misaligned`  out  1  registered: last accepted redirect had bit 1 set.
- `ras_empty`  out  1  RAS count == 0.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid entries.

## Operation
- B-immediate: sign-extend of {inst_DX[31], inst_DX[7], inst_DX[30:25], inst_DX[11:8], 0}. Branch target = `PC_DX` + imm, modulo 2^XLEN.
- `PC_plus_4` = `PC_IF` + 4, modulo 2^XLEN; wrap from all-ones−3 to 0 is legal.
- `PC_PIF` per `PC_src_sel`:
  - PLUS_FOUR gives `PC_plus_4`.
  - JAL_TARGET gives `alu_out`.
  - REG_TARGET gives `rs1_data`.
  - BRANCH_TARGET gives the branch target.
  - REPLAY gives `PC_IF`.
  - STVEC gives `csr_stvec`.
  - RAS_TARGET gives the RAS top if non-empty, else `rs1_data`.
  - Code 7 gives `PC_plus_4`.
- While `reset` is high, `PC_PIF` = `RESET_VECTOR`.
- Accept = `!reset && !stall_IF`. On accept, `PC_IF` <= `PC_PIF`.
- `target_misaligned`:
  - On accept with sel ∈ {1,2,3,5,6}, it loads `PC_PIF[1]`.
  - On accept with sel ∈ {0,4,7}, it loads 0.
  - It holds while stalled.
- RAS is a circular buffer with a top pointer and a saturating count. All updates happen only on accept.
  - Push only (`ras_push_DX`, sel≠6): write `PC_DX+4` at top+1, advance top, count+1 saturating at `RAS_DEPTH`. When full, the oldest entry is overwritten (pointer wraps).
  - Pop only (sel=6, `ras_push_DX`=0, count>0): retreat top, count−1.
  - Pop with count=0: no state change; target falls back to `rs1_data`.
  - Push and pop together (sel=6, `ras_push_DX`=1): the top entry is overwritten with `PC_DX+4` and the pointer is unchanged. Count is unchanged if non-empty; if empty it becomes 1.
- Reset mid-operation discards all RAS contents (count=0); entry data is don't-care.

## Timing
- Reset values: `PC_IF`=`RESET_VECTOR`, `target_misaligned`=0, `ras_count`=0, `ras_empty`=1, top pointer=0.
- `PC_PIF` is combinational from the inputs and current state within the same cycle. There is no combinational path from `PC_PIF` back to `stall_IF`.
- Redirect latency: a select asserted in cycle N appears on `PC_IF` in cycle N+1 if not stalled.
- Stall: `PC_IF`, the RAS and `target_misaligned` hold for every stalled cycle. `PC_PIF` still reflects the current select.
- RAS top read is combinational from current state. A push in cycle N is visible to a RAS_TARGET in cycle N+1.
- Reset has priority over stall and all selects.

## Test plan
- Reset, release, sel=0 for three cycles -> `PC_IF` = 0x200, 0x204, 0x208, 0x20C; `ras_empty`=1.
- `PC_IF`=0x100, `PC_DX`=0xFC, sel=3, branch imm = −8 -> `PC_PIF`=0xF4, next `PC_IF`=0xF4, `target_misaligned`=0. Repeat with `PC_DX`=0xFE -> `PC_PIF`=0xF6, `target_misaligned`=1.
- Push 5 calls with `PC_DX`=0x10,0x20,0x30,0x40,0x50 (`RAS_DEPTH`=4) -> `ras_count`=4. Five pops return 0x54, 0x44, 0x34, 0x24, then `rs1_data` with `ras_empty`=1.
- Simultaneous push (`PC_DX`=0x80) and sel=6 with top=0x34, count=2 -> `PC_PIF`=0x34, top becomes 0x84, count stays 2.
- `stall_IF`=1 for 3 cycles with sel=1, `alu_out`=0x400 -> `PC_IF` unchanged and RAS unchanged. First unstalled cycle gives `PC_IF`=0x400 next cycle.
- `PC_IF`=0xFFFF_FFFC, sel=0 -> `PC_IF`=0x0. Assert `reset` while count=3 -> next cycle `PC_IF`=0x200, `ras_count`=0.
